// File: rtl/vga_bounce_gen.sv
// vga_bounce_gen: bouncing solid-square test pattern feeding vga_core, one position update per FRAME_DIV frames.
// Define VGA_BOUNCE_BORDER_EN to overlay a white 1-pixel border around the active area.
module vga_bounce_gen #(
  parameter int          BOX_SIZE  = 32,
  parameter int          STEP      = 2,
  parameter int          FRAME_DIV = 1,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic        pxl_clk,
  input  logic        pxl_rstn,
  input  logic [31:0] horz_res,
  input  logic [31:0] vert_res,
  input  logic        horz_active,
  input  logic        vert_active,
  input  logic        frame_active,
  input  logic        move_en,
  output logic [3:0]  rgb_red,
  output logic [3:0]  rgb_green,
  output logic [3:0]  rgb_blue,
  output logic [15:0] bounce_cnt
);
  typedef enum logic {INC, DEC} dir_t;
  typedef struct packed {
    logic        bnc;
    dir_t        dir;
    logic [11:0] pos;
  } axis_t;
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);
  logic [11:0] x_cnt, y_cnt, box_x, box_y, pix;
  logic        h_q, v_q, frame_end, update, in_box;
  dir_t        dir_x, dir_y;
  axis_t       ax, ay;
  logic [2:0]  col;
  logic [7:0]  div;
  // One axis of motion: a resolution not larger than the box pins it at 0 with no bounce
  function automatic axis_t step_axis(input logic [11:0] pos, input dir_t dir, input logic [31:0] res);
    axis_t       r;
    logic [31:0] p;
    p = {20'd0, pos};
    r.bnc = 1'b0;
    r.dir = dir;
    r.pos = 12'd0;
    if (res > BOX_SIZE) begin
      if (dir == INC) begin
        if (p + BOX_SIZE + STEP >= res) begin
          r.bnc = 1'b1;
          r.dir = DEC;
          r.pos = 12'(res - BOX_SIZE);
        end else r.pos = 12'(p + STEP);
      end else begin
        if (p <= STEP) begin
          r.bnc = 1'b1;
          r.dir = INC;
        end else r.pos = 12'(p - STEP);
      end
    end
    return r;
  endfunction
  always_comb begin
    frame_end = v_q & ~vert_active;
    update    = frame_end && div == DIV_LAST && move_en;
    ax        = step_axis(box_x, dir_x, horz_res);
    ay        = step_axis(box_y, dir_y, vert_res);
    in_box    = x_cnt >= box_x && {20'd0, x_cnt} < {20'd0, box_x} + BOX_SIZE &&
                y_cnt >= box_y && {20'd0, y_cnt} < {20'd0, box_y} + BOX_SIZE;
    pix       = !frame_active ? 12'h000 : in_box ? {{4{col[2]}}, {4{col[1]}}, {4{col[0]}}} : BG_COLOR;
`ifdef VGA_BOUNCE_BORDER_EN
    if (frame_active && (x_cnt == 12'd0 || {20'd0, x_cnt} == horz_res - 32'd1 ||
                         y_cnt == 12'd0 || {20'd0, y_cnt} == vert_res - 32'd1))
      pix = 12'hFFF;
`endif
  end
  always_ff @(posedge pxl_clk or negedge pxl_rstn) begin
    if (!pxl_rstn) begin
      {rgb_red, rgb_green, rgb_blue} <= 12'h000;
      bounce_cnt <= 16'd0;
      box_x      <= 12'd0;
      box_y      <= 12'd0;
      dir_x      <= INC;
      dir_y      <= INC;
      col        <= 3'd1;
      div        <= 8'd0;
      x_cnt      <= 12'd0;
      y_cnt      <= 12'd0;
      h_q        <= 1'b0;
      v_q        <= 1'b0;
    end else begin
      {rgb_red, rgb_green, rgb_blue} <= pix;
      h_q   <= horz_active;
      v_q   <= vert_active;
      x_cnt <= !horz_active ? 12'd0 : frame_active ? x_cnt + 12'd1 : x_cnt;
      y_cnt <= !vert_active ? 12'd0 : (h_q && !horz_active) ? y_cnt + 12'd1 : y_cnt;
      if (frame_end) div <= (div == DIV_LAST) ? 8'd0 : div + 8'd1;
      if (update) begin
        box_x <= ax.pos;
        box_y <= ay.pos;
        dir_x <= ax.dir;
        dir_y <= ay.dir;
        if (ax.bnc || ay.bnc) begin
          col        <= (col == 3'd7) ? 3'd1 : col + 3'd1;
          bounce_cnt <= bounce_cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_bounce_gen.sv
// tb_vga_bounce_gen: directed checks of the bouncing square, using short synthetic lines/frames.
// A second instance with FRAME_DIV=4 shares all inputs.
module tb_vga_bounce_gen;
  logic        clk = 1'b0, rstn = 1'b0;
  logic [31:0] horz_res = 32'd640, vert_res = 32'd480;
  logic        horz = 1'b0, vert = 1'b0, frame = 1'b0, move_en = 1'b0;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic [15:0] bc_a, bc_b;
  logic [11:0] ga, gb;
  int          n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  vga_bounce_gen u_dut (
    .pxl_clk(clk), .pxl_rstn(rstn), .horz_res(horz_res), .vert_res(vert_res),
    .horz_active(horz), .vert_active(vert), .frame_active(frame), .move_en(move_en),
    .rgb_red(r_a), .rgb_green(g_a), .rgb_blue(b_a), .bounce_cnt(bc_a)
  );
  vga_bounce_gen #(.FRAME_DIV(4)) u_div4 (
    .pxl_clk(clk), .pxl_rstn(rstn), .horz_res(horz_res), .vert_res(vert_res),
    .horz_active(horz), .vert_active(vert), .frame_active(frame), .move_en(move_en),
    .rgb_red(r_b), .rgb_green(g_b), .rgb_blue(b_b), .bounce_cnt(bc_b)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask
  // n minimal frames, each ending in a vert_active falling edge
  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk); vert = 1'b1;
      @(negedge clk); vert = 1'b0;
    end
    @(negedge clk);
  endtask
  // Walk py one-pixel lines, then a line up to pixel px; capture both outputs for pixel (px,py)
  task automatic probe(input int px, input int py, output logic [11:0] oa, output logic [11:0] ob);
    @(negedge clk); vert = 1'b1;
    repeat (py) begin
      @(negedge clk); horz = 1'b1; frame = 1'b1;
      @(negedge clk); horz = 1'b0; frame = 1'b0;
    end
    for (int i = 0; i <= px; i++) begin
      @(negedge clk);
      if (i == 0) chk("lat_pre", {r_a, g_a, b_a}, 12'h000);
      horz = 1'b1; frame = 1'b1;
    end
    @(negedge clk);
    oa = {r_a, g_a, b_a};
    ob = {r_b, g_b, b_b};
    horz = 1'b0; frame = 1'b0;
    @(negedge clk);
    chk("lat_post", {r_a, g_a, b_a}, 12'h000);
    vert = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rgb", {r_a, g_a, b_a}, 12'h000);
    chk("rst_bc", bc_a, 16'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_bc_b", bc_b, 16'd0);
    probe(0, 0, ga, gb);    chk("f0_px0_0", ga, 12'h00F); chk("f0_px0_0_b", gb, 12'h00F);
    probe(31, 31, ga, gb);  chk("f0_px31_31", ga, 12'h00F);
    probe(32, 5, ga, gb);   chk("f0_px32_5", ga, 12'h000);
    probe(5, 32, ga, gb);   chk("f0_px5_32", ga, 12'h000);
    // corner hit on a 64x64 area
    do_reset();
    horz_res = 32'd64; vert_res = 32'd64; move_en = 1'b1;
    frames(15);
    move_en = 1'b0;
    chk("cor_bc0", bc_a, 16'd0);
    probe(30, 30, ga, gb);  chk("cor_px30", ga, 12'h00F);
    probe(29, 30, ga, gb);  chk("cor_px29", ga, 12'h000);
    move_en = 1'b1;
    frames(1);
    move_en = 1'b0;
    chk("cor_bc1", bc_a, 16'd1);
    probe(32, 32, ga, gb);  chk("cor_px32", ga, 12'h0F0);
    probe(63, 63, ga, gb);  chk("cor_px63", ga, 12'h0F0);
    probe(31, 32, ga, gb);  chk("cor_px31", ga, 12'h000);
    // frame divider and move_en freeze
    do_reset();
    horz_res = 32'd640; vert_res = 32'd480; move_en = 1'b1;
    frames(3);
    move_en = 1'b0;
    probe(0, 0, ga, gb);    chk("div_a_moved", ga, 12'h000); chk("div_b_held", gb, 12'h00F);
    move_en = 1'b1;
    frames(4);
    move_en = 1'b0;
    probe(1, 1, ga, gb);    chk("div_b_px1", gb, 12'h000);
    probe(2, 2, ga, gb);    chk("div_b_px2", gb, 12'h00F); chk("div_a_px2", ga, 12'h000);
    probe(14, 14, ga, gb);  chk("div_a_px14", ga, 12'h00F);
    frames(10);
    chk("frz_bc", bc_a, 16'd0);
    probe(14, 14, ga, gb);  chk("frz_px14", ga, 12'h00F);
    probe(13, 14, ga, gb);  chk("frz_px13", ga, 12'h000);
    // asynchronous reset in the middle of a box-covered line
    @(negedge clk); vert = 1'b1;
    repeat (14) begin
      @(negedge clk); horz = 1'b1; frame = 1'b1;
      @(negedge clk); horz = 1'b0; frame = 1'b0;
    end
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk); horz = 1'b1; frame = 1'b1;
    end
    @(negedge clk);
    chk("pre_rst", {r_a, g_a, b_a}, 12'h00F);
    rstn = 1'b0;
    #1;
    chk("rst_async", {r_a, g_a, b_a}, 12'h000);
    horz = 1'b0; frame = 1'b0; vert = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    probe(0, 0, ga, gb);    chk("post_rst_px0", ga, 12'h00F);
    probe(32, 0, ga, gb);   chk("post_rst_px32", ga, 12'h000);
    // long run: Y bounces at update 224, X at update 304
    do_reset();
    move_en = 1'b1;
    frames(223); chk("run_bc223", bc_a, 16'd0);
    frames(1);   chk("run_bc224", bc_a, 16'd1);
    frames(79);  chk("run_bc303", bc_a, 16'd1);
    frames(1);   chk("run_bc304", bc_a, 16'd2);
    chk("run_bc_b", bc_b, 16'd0);
    move_en = 1'b0;
    probe(608, 288, ga, gb); chk("run_px608_288", ga, 12'h0FF); chk("run_b_px608", gb, 12'h000);
    probe(607, 288, ga, gb); chk("run_px607_288", ga, 12'h000);
    probe(639, 319, ga, gb); chk("run_px639_319", ga, 12'h0FF);
    probe(608, 320, ga, gb); chk("run_px608_320", ga, 12'h000);
    probe(639, 240, ga, gb); chk("run_px639_240", ga, 12'h000);
    probe(152, 152, ga, gb); chk("run_b_px152", gb, 12'h00F); chk("run_a_px152", ga, 12'h000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
